// File: rtl/tpu_pkg.sv
// Shared types and constants for the 2x2 systolic matrix unit sequencer.
// The feed schedule packs one cycle's selects as {a0, a1, b0, b1}.
package tpu_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_CAPTURE,
        ST_OUT
    } state_e;

    localparam logic [1:0] SEL_K0   = 2'b00;
    localparam logic [1:0] SEL_K1   = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;

    localparam logic [2:0] ADDR_W0 = 3'd0;
    localparam logic [2:0] ADDR_I0 = 3'd4;

    localparam logic [2:0] OUT_LAST_NARROW = 3'd3;
    localparam logic [2:0] OUT_LAST_WIDE   = 3'd7;

    // Row 1 / column 1 run one cycle behind row 0 / column 0 (skewed feed).
    localparam logic [3:0][7:0] FEED_SCHED = {
        {SEL_ZERO, SEL_ZERO, SEL_ZERO, SEL_ZERO},
        {SEL_ZERO, SEL_K1,   SEL_ZERO, SEL_K1  },
        {SEL_K1,   SEL_K0,   SEL_K1,   SEL_K0  },
        {SEL_K0,   SEL_ZERO, SEL_K0,   SEL_ZERO}
    };
endpackage

// File: rtl/result_serializer.sv
// Captures the four accumulators, optionally clamps them to int8, and streams
// the result bytes out over a valid/ready handshake.
module result_serializer
    import tpu_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort_i,
    input  logic             capture_i,
    input  logic             wide_i,
    input  logic [ACC_W-1:0] c00_i,
    input  logic [ACC_W-1:0] c01_i,
    input  logic [ACC_W-1:0] c10_i,
    input  logic [ACC_W-1:0] c11_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [7:0]       out_data_o,
    output logic             last_o
);
    localparam logic signed [ACC_W-1:0] SAT_MAX = 127;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -128;

    logic [3:0][ACC_W-1:0] acc;
    logic [3:0][7:0]       sat_b;
    logic [7:0][7:0]       buf_q, buf_d;
    logic [2:0]            idx_q, last_q;
    logic                  vld_q;

    assign acc = {c11_i, c10_i, c01_i, c00_i};

    for (genvar e = 0; e < 4; e++) begin : g_sat
        assign sat_b[e] = ($signed(acc[e]) > SAT_MAX) ? 8'h7F :
                          ($signed(acc[e]) < SAT_MIN) ? 8'h80 : acc[e][7:0];
    end

    // Wide: low/high byte per element. Narrow: one clamped byte per element.
    for (genvar b = 0; b < 8; b++) begin : g_byte
        localparam int EL = b / 2;
        logic [7:0] wb;
        assign wb       = (b % 2 == 1) ? acc[EL][15:8] : acc[EL][7:0];
        assign buf_d[b] = wide_i ? wb : ((b < 4) ? sat_b[b % 4] : 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            idx_q  <= '0;
            last_q <= '0;
            vld_q  <= 1'b0;
        end else if (abort_i) begin
            vld_q <= 1'b0;
            idx_q <= '0;
        end else if (capture_i) begin
            buf_q  <= buf_d;
            last_q <= wide_i ? OUT_LAST_WIDE : OUT_LAST_NARROW;
            idx_q  <= '0;
            vld_q  <= 1'b1;
        end else if (vld_q && out_ready_i) begin
            if (idx_q == last_q) begin
                vld_q <= 1'b0;
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    assign out_valid_o = vld_q;
    assign out_data_o  = vld_q ? buf_q[idx_q] : 8'h00;
    assign last_o      = vld_q & out_ready_i & (idx_q == last_q) & ~abort_i;
endmodule

// File: rtl/mmu_sequencer.sv
// Job sequencer for the 2x2 systolic array: loads 8 operand bytes, runs the
// clear/feed/drain schedule, then hands the accumulators to the serializer.
module mmu_sequencer
    import tpu_pkg::*;
#(
    parameter int ACC_W        = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             out_wide,
    output logic             mem_we,
    output logic [2:0]       mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             clear,
    output logic [1:0]       a0_sel,
    output logic [1:0]       a1_sel,
    output logic [1:0]       b0_sel,
    output logic [1:0]       b1_sel,
    input  logic [ACC_W-1:0] c00,
    input  logic [ACC_W-1:0] c01,
    input  logic [ACC_W-1:0] c10,
    input  logic [ACC_W-1:0] c11,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic             done
);
    localparam int CW = 8;

    state_e        state_q, state_d;
    logic [2:0]    addr_q, addr_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          wide_q, wide_d;
    logic          hs_in, last_out;

    // Gated by rst_n so in_ready is low for the whole reset window.
    assign in_ready  = rst_n & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
    assign hs_in     = in_valid & in_ready;
    assign mem_we    = hs_in;
    assign mem_addr  = addr_q;
    assign mem_wdata = in_data;
    assign clear     = (state_q == ST_CLEAR);
    assign busy      = (state_q != ST_IDLE);
    assign done      = last_out;

    always_comb begin
        {a0_sel, a1_sel, b0_sel, b1_sel} = {4{SEL_ZERO}};
        if (state_q == ST_FEED) {a0_sel, a1_sel, b0_sel, b1_sel} = FEED_SCHED[cyc_q[1:0]];
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cyc_d   = cyc_q;
        wide_d  = wide_q;
        unique case (state_q)
            ST_IDLE: if (hs_in) begin
                wide_d  = out_wide;
                addr_d  = addr_q + 3'd1;
                state_d = ST_LOAD;
            end
            ST_LOAD: if (hs_in) begin
                addr_d = addr_q + 3'd1;
                if (addr_q == ADDR_I0 + 3'd3) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                cyc_d   = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CW'(3)) begin
                    cyc_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CW'(DRAIN_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_d = ST_OUT;
            ST_OUT:     if (last_out) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            addr_d  = ADDR_W0;
            cyc_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= ADDR_W0;
            cyc_q   <= '0;
            wide_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cyc_q   <= cyc_d;
            wide_q  <= wide_d;
        end
    end

    result_serializer #(.ACC_W(ACC_W)) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort_i    (abort),
        .capture_i  (state_q == ST_CAPTURE),
        .wide_i     (wide_q),
        .c00_i      (c00),
        .c01_i      (c01),
        .c10_i      (c10),
        .c11_i      (c11),
        .out_ready_i(out_ready),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .last_o     (last_out)
    );
endmodule

// File: tb/tb_mmu_sequencer.sv
// Scoreboard bench: a matrix-multiply reference fills the expected-byte queue,
// a behavioural 2x2 array answers the selects, and a monitor checks results.
module tb_mmu_sequencer;
    logic        clk = 0, rst_n = 0, abort = 0, in_valid = 0, out_wide = 0, out_ready = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, mem_we, clear, out_valid, busy, done;
    logic [2:0]  mem_addr;
    logic [7:0]  mem_wdata, out_data;
    logic [1:0]  a0_sel, a1_sel, b0_sel, b1_sel;
    logic [15:0] c00, c01, c10, c11;

    always #5 clk = ~clk;

    mmu_sequencer #(.ACC_W(16), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_wide(out_wide), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .clear(clear), .a0_sel(a0_sel), .a1_sel(a1_sel),
        .b0_sel(b0_sel), .b1_sel(b1_sel), .c00(c00), .c01(c01), .c10(c10), .c11(c11),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
    );

    int checks = 0, errors = 0;
    typedef struct { logic [7:0] d; bit last; } exp_t;
    exp_t exp_q[$];
    bit   rand_rdy = 0;
    logic man_rdy  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: required event did not occur within bound at %0t", nm, $time);
    endtask

    // ---------------- environment: operand memory + skewed 2x2 array ----------------
    byte      mem [8];
    int       acc [4];
    int       av_d [2], bv_d [2];
    bit       s_we, s_clr;
    bit [2:0] s_addr;
    bit [7:0] s_wd;
    bit [1:0] s_sel [4];

    function automatic int opv(input bit [1:0] s, input byte k0, input byte k1);
        return (s == 2'b00) ? int'(k0) : (s == 2'b01) ? int'(k1) : 0;
    endfunction

    always @(negedge clk) begin
        s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata; s_clr = clear;
        s_sel[0] = a0_sel; s_sel[1] = a1_sel; s_sel[2] = b0_sel; s_sel[3] = b1_sel;
    end

    always @(posedge clk) begin
        int av [2], bv [2];
        for (int i = 0; i < 2; i++) av[i] = opv(s_sel[i], mem[4 + 2*i], mem[5 + 2*i]);
        for (int j = 0; j < 2; j++) bv[j] = opv(s_sel[2 + j], mem[j], mem[2 + j]);
        if (s_clr) begin
            for (int e = 0; e < 4; e++) acc[e] <= 0;
        end else begin
            acc[0] <= acc[0] + av[0]   * bv[0];
            acc[1] <= acc[1] + av_d[0] * bv[1];
            acc[2] <= acc[2] + av[1]   * bv_d[0];
            acc[3] <= acc[3] + av_d[1] * bv_d[1];
        end
        av_d <= av;
        bv_d <= bv;
        if (s_we) mem[s_addr] <= byte'(s_wd);
    end

    assign c00 = acc[0][15:0];
    assign c01 = acc[1][15:0];
    assign c10 = acc[2][15:0];
    assign c11 = acc[3][15:0];

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : man_rdy;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_byte: got %0h expected no byte at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("done_on_hs", done, e.last);
                end
            end else if (busy) begin
                chk("no_done", done, 0);
            end
        end
    end

    // ---------------- reference model + stimulus ----------------
    task automatic push_exp(input logic [7:0][7:0] jb, input bit wide);
        for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
            int c, cs;
            logic [15:0] cw;
            exp_t x;
            c = 0;
            for (int k = 0; k < 2; k++)
                c += int'($signed(jb[4 + 2*i + k])) * int'($signed(jb[2*k + j]));
            cw = c[15:0];
            cs = int'($signed(cw));
            if (wide) begin
                x.d = cw[7:0];  x.last = 0;                  exp_q.push_back(x);
                x.d = cw[15:8]; x.last = (i == 1 && j == 1); exp_q.push_back(x);
            end else begin
                x.d = (cs > 127) ? 8'h7F : (cs < -128) ? 8'h80 : cw[7:0];
                x.last = (i == 1 && j == 1);
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic put_byte(input logic [7:0] b, input bit gap);
        int n;
        bit ok;
        if (gap && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        in_valid = 1; in_data = b; n = 0; ok = 0;
        while (!ok && n < 50) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; n++;
        end
        in_valid = 0;
        if (!ok) fail("in_ready_timeout");
    endtask

    // Returns in cycle T+1 (T = cycle of the 8th accepted byte).
    task automatic send_job(input logic [7:0][7:0] jb, input bit wide, input bit gap);
        push_exp(jb, wide);
        out_wide = wide;
        for (int i = 0; i < 8; i++) put_byte(jb[i], gap);
    endtask

    task automatic check_sched();
        logic [7:0] tbl [4];
        logic [7:0] ex;
        tbl[0] = 8'b00_10_00_10; tbl[1] = 8'b01_00_01_00;
        tbl[2] = 8'b10_01_10_01; tbl[3] = 8'b10_10_10_10;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            ex = (c >= 2 && c <= 5) ? tbl[c - 2] : 8'hAA;
            chk($sformatf("sched_T+%0d", c), {clear, a0_sel, a1_sel, b0_sel, b1_sel}, {(c == 1), ex});
            chk($sformatf("ovalid_T+%0d", c), out_valid, (c == 9));
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin @(posedge clk); #1; n++; end
        if (n >= 3000) fail("idle_timeout");
    endtask

    task automatic wait_ovalid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 40);
        if (!out_valid) fail("out_valid_timeout");
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ctl"}, {in_ready, mem_we, mem_addr, clear, out_valid, out_data, busy, done}, 0);
        chk({nm, "_sel"}, {a0_sel, a1_sel, b0_sel, b1_sel}, 8'hAA);
    endtask

    localparam logic [63:0] ID_JOB  = {8'd4, 8'd3, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1};
    localparam logic [63:0] HUN_JOB = {8{8'd100}};
    localparam logic [63:0] NEG_JOB = {{4{8'h80}}, {4{8'h7F}}};

    initial begin
        logic [7:0][7:0] jb;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        chk("idle_ready", in_ready, 1);

        man_rdy = 1;
        jb = ID_JOB;  send_job(jb, 0, 0); check_sched(); wait_idle();
        jb = HUN_JOB; send_job(jb, 1, 0); check_sched(); wait_idle();
        jb = HUN_JOB; send_job(jb, 0, 0); wait_idle();
        jb = NEG_JOB; send_job(jb, 0, 0); wait_idle();
        jb = NEG_JOB; send_job(jb, 1, 1); wait_idle();

        rand_rdy = 1;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 8; i++) jb[i] = 8'($urandom);
            send_job(jb, 1'($urandom_range(0, 1)), 1);
            check_sched();
            wait_idle();
        end
        rand_rdy = 0;

        // Backpressure: one byte leaves, then out_ready low for 5 cycles.
        man_rdy = 0;
        jb = ID_JOB; send_job(jb, 0, 0); wait_ovalid();
        @(posedge clk); #1 man_rdy = 1;
        @(posedge clk); #1 man_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            @(negedge clk);
            chk("bp_data", out_data, 8'h02);
            chk("bp_ignore", {in_ready, mem_we, out_valid}, 3'b001);
            @(posedge clk); #1;
        end
        in_valid = 0; man_rdy = 1;
        wait_idle();

        // Reset in the middle of FEED.
        jb = ID_JOB; send_job(jb, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 0;
        #1 chk_reset_vals("midfeed_reset");
        exp_q.delete();
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        chk("post_reset_idle", {busy, in_ready}, 2'b01);

        // Abort during OUT, coinciding with a handshake.
        man_rdy = 0;
        jb = ID_JOB; send_job(jb, 0, 0); wait_ovalid();
        @(posedge clk); #1 man_rdy = 1;
        @(posedge clk); #1 abort = 1;
        @(negedge clk) chk("abort_no_done", done, 0);
        @(posedge clk); #1 abort = 0;
        exp_q.delete();
        @(negedge clk) chk("abort_idle", {busy, out_valid, in_ready}, 3'b001);
        @(posedge clk); #1;
        jb = ID_JOB; send_job(jb, 0, 0); check_sched(); wait_idle();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mmu_sequencer.md
# mmu_sequencer

Job-level sequencer for the 2x2 systolic matrix unit. Accepts a stream of 8 operand bytes over a valid/ready handshake and writes them into operand memory. It then runs the clear / skewed-feed / drain schedule on the array's operand selects, captures the four accumulators, and streams the result back byte-wise over a second valid/ready handshake. It sits between the host byte interface and the memory + systolic array pair.

## Interface
Parameters:
- ACC_W, 16, accumulator width of c00..c11 (signed)
- DRAIN_CYCLES, 2, idle cycles after the last feed before accumulators are final (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- abort  in  1  synchronous job abort
- in_valid  in  1  operand byte valid
- in_ready  out  1  operand byte accepted when in_valid&in_ready
- in_data  in  8  operand byte
- out_wide  in  1  sampled on the first accepted byte: 1 = 16-bit results, 0 = int8-saturated results
- mem_we  out  1  operand memory write strobe
- mem_addr  out  3  memory address: 0-3 weight0..3 (B, row-major), 4-7 input0..3 (A, row-major)
- mem_wdata  out  8  byte to memory
- clear  out  1  accumulator clear to array
- a0_sel, a1_sel, b0_sel, b1_sel  out  2 each  operand select: 2'b00 k=0, 2'b01 k=1, 2'b10 zero, 2'b11 never driven
- c00, c01, c10, c11  in  ACC_W each  array accumulators (C = A x B)
- out_valid  out  1  result byte valid
- out_ready  in  1  result byte consumed when out_valid&out_ready
- out_data  out  8  result byte
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on acceptance of the last result byte

## Operation
- States: IDLE, LOAD, CLEAR, FEED, DRAIN, CAPTURE, OUT.
- IDLE: in_ready=1. The first accepted byte is written to addr 0, out_wide is latched, and the state goes to LOAD.
- LOAD: in_ready=1. Each accepted byte is written to the address given by the byte counter. After the byte to addr 7 is accepted, the state goes to CLEAR. in_valid is ignored in every other state.
- mem_we = in_valid & in_ready (combinational). mem_wdata = in_data. mem_addr = the byte counter.
- CLEAR: clear=1 for exactly one cycle.
- FEED: 4 cycles, f=0..3, selects given as (a0,a1,b0,b1):
  - f0: (00,10,00,10)
  - f1: (01,00,01,00)
  - f2: (10,01,10,01)
  - f3: all 10
- All selects are 10 outside FEED.
- DRAIN: DRAIN_CYCLES cycles with no action.
- CAPTURE: 1 cycle. Registers c00,c01,c10,c11 into the result buffer; saturation is applied here when narrow.
- Narrow mode: a signed clamp to [-128,127], giving 4 bytes in order c00,c01,c10,c11.
- Wide mode: 8 bytes, low byte then high byte per element, in the same element order. Bits above 16 are not emitted.
- OUT: out_valid=1 and out_data holds stable until accepted. The index advances only on a handshake. done pulses on the last handshake, and the state returns to IDLE the next cycle.
- abort=1 in any state: next state IDLE, counters cleared, no done pulse. abort in IDLE is a no-op. abort has priority over a simultaneous handshake.
- Reset values: in_ready=0 while rst_n low, then 1 in IDLE. All other outputs are 0 except the selects, which are 2'b10. State is IDLE.

## Timing
- Let T be the cycle the 8th byte is accepted.
  - T+1: CLEAR.
  - T+2..T+5: FEED.
  - T+6..T+5+DRAIN_CYCLES: DRAIN.
  - T+6+DRAIN_CYCLES: CAPTURE.
  - From T+7+DRAIN_CYCLES: out_valid=1. With the default parameters, out_valid first rises in T+9.
- Back-to-back bytes: one per cycle, no bubbles required.
- With out_ready held high, one byte leaves per cycle.
- The next job's first byte can be accepted in the cycle after done.
- Reset asserted mid-job (any state) immediately forces the reset values. No partial output is resumed.

## Structure
- Package tpu_pkg holds:
  - the state enum;
  - select constants SEL_K0, SEL_K1, SEL_ZERO;
  - address constants ADDR_W0=0, ADDR_I0=4;
  - the 4-entry feed schedule as constants.
- Sub-module result_serializer: capture registers, int8 saturation, byte mux and out handshake. It is driven by capture/start strobes from the FSM.

## Test plan
- Identity: W=[1,0,0,1], I=[1,2,3,4], narrow -> out bytes 01,02,03,04. done is a single pulse and out_valid first rises exactly 9 cycles after the 8th byte.
- Wide overflow of int8: W and I all 100, wide -> each c=20000, bytes 20,4E repeated 4 times. The same job narrow -> 7F x4.
- Negative saturation: I=[0x80,0x80,0x80,0x80], W all 0x7F, narrow -> c=-32512 -> 80 x4. Wide -> 00,81 x4.
- Schedule check: monitor clear and the selects from T+1..T+6 against the FEED table. clear is high only at T+1, and the selects are 10 elsewhere.
- Backpressure/ignore: hold out_ready=0 for 5 cycles mid-OUT -> out_data stable, in_ready=0, and in_valid pulses cause no mem_we.
- Reset and abort: assert rst_n low during FEED -> all outputs at reset values. Assert abort during OUT -> IDLE next cycle, no done. The following identity job then yields 01,02,03,04.
